// File: rtl/vga_tile_renderer.sv
// vga_tile_renderer -- VGA sync generator with a scrolled tile-map background and
// colour-keyed sprite overlay, four pipeline stages from counters to registered RGB. Rev 1.0
`default_nettype none
module vga_tile_renderer #(
  parameter int          H_SYNC     = 112,
  parameter int          H_BACK     = 248,
  parameter int          H_ACTIVE   = 1280,
  parameter int          H_FRONT    = 48,
  parameter int          V_SYNC     = 3,
  parameter int          V_BACK     = 38,
  parameter int          V_ACTIVE   = 1024,
  parameter int          V_FRONT    = 1,
  parameter int          IMG_H      = 896,
  parameter int          TILE_LOG2  = 6,
  parameter int          MAP_W      = 212,
  parameter int          MAP_AW     = 12,
  parameter int          ATLAS_AW   = 18,
  parameter int          ATLAS_W    = 640,
  parameter int          NSPR       = 2,
  parameter logic [15:0] KEY        = 16'd23743,
  parameter int          SCROLL_MAX = 12160
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [13:0]              scroll_in,
  input  logic                     scroll_we,
  input  logic [NSPR-1:0]          spr_en,
  input  logic [NSPR*11-1:0]       spr_x,
  input  logic [NSPR*10-1:0]       spr_y,
  input  logic [NSPR*ATLAS_AW-1:0] spr_base,
  output logic [MAP_AW-1:0]        map_addr,
  input  logic [5:0]               map_data,
  output logic [ATLAS_AW-1:0]      tile_addr,
  input  logic [15:0]              tile_data,
  output logic [NSPR*ATLAS_AW-1:0] spr_addr,
  input  logic [NSPR*16-1:0]       spr_data,
  output logic [3:0]               red,
  output logic [3:0]               green,
  output logic [3:0]               blue,
  output logic                     hs,
  output logic                     vs,
  output logic                     frame_start
);
  localparam int COL  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int ROW  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HOFF = H_SYNC + H_BACK;
  localparam int VOFF = V_SYNC + V_BACK;
  localparam int TILE = 1 << TILE_LOG2;
  localparam int TPR  = ATLAS_W >> TILE_LOG2;
  localparam int HW   = $clog2(COL);
  localparam int VW   = $clog2(ROW);

  localparam logic [HW-1:0] H_LO   = HW'(HOFF);
  localparam logic [HW-1:0] H_HI   = HW'(HOFF + H_ACTIVE);
  localparam logic [HW-1:0] H_SY   = HW'(H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(COL - 1);
  localparam logic [VW-1:0] V_LO   = VW'(VOFF);
  localparam logic [VW-1:0] V_HI   = VW'(VOFF + V_ACTIVE);
  localparam logic [VW-1:0] V_SY   = VW'(V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(ROW - 1);
  localparam logic [13:0]   SMAX   = 14'(SCROLL_MAX);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [13:0]   pending, scroll;

  logic          active_c, draw_c, hs_c, vs_c, fs_c;
  logic [10:0]   x_c;
  logic [9:0]    y_c;
  logic [14:0]   wx_c;
  logic [NSPR-1:0] hit_c;
  logic [11:0]   dx_c [NSPR];
  logic [10:0]   dy_c [NSPR];

  logic [TILE_LOG2-1:0] tx1, ty1;
  logic                 draw1, draw2, draw3;
  logic [NSPR-1:0]      hit1, hit2, hit3;
  logic [TILE_LOG2-1:0] dx1 [NSPR];
  logic [TILE_LOG2-1:0] dy1 [NSPR];
  logic [ATLAS_AW-1:0]  base1 [NSPR];

  logic [ATLAS_AW-1:0]      tile_nxt;
  logic [NSPR*ATLAS_AW-1:0] spr_nxt;
  logic [15:0]              tile_pix3, pix_c;
  logic [NSPR*16-1:0]       spr_pix3;
  logic [3:0]               hs_d, vs_d, fs_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      pending <= '0;
      scroll  <= '0;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
      if (scroll_we) pending <= scroll_in;
      // scroll only moves at the top-left corner so a frame never tears
      if (h_cnt == '0 && v_cnt == '0) scroll <= (pending > SMAX) ? SMAX : pending;
    end
  end

  always_comb begin
    active_c = (h_cnt >= H_LO) && (h_cnt < H_HI) && (v_cnt >= V_LO) && (v_cnt < V_HI);
    x_c      = 11'(h_cnt) - 11'(HOFF);
    y_c      = 10'(v_cnt) - 10'(VOFF);
    wx_c     = 15'(x_c) + 15'(scroll);
    draw_c   = active_c && (y_c < 10'(IMG_H));
    hs_c     = (h_cnt >= H_SY);
    vs_c     = (v_cnt >= V_SY);
    fs_c     = (h_cnt == '0) && (v_cnt == '0);
    hit_c    = '0;
    for (int i = 0; i < NSPR; i++) begin
      dx_c[i]  = 12'(x_c) - 12'(spr_x[i*11 +: 11]);
      dy_c[i]  = 11'(y_c) - 11'(spr_y[i*10 +: 10]);
      hit_c[i] = spr_en[i] && active_c
                 && (x_c >= spr_x[i*11 +: 11]) && (dx_c[i] < 12'(TILE))
                 && (y_c >= spr_y[i*10 +: 10]) && (dy_c[i] < 11'(TILE));
    end
  end

  always_comb begin
    tile_nxt = ATLAS_AW'((32'(map_data) % 32'(TPR)) * 32'(TILE)
                       + (32'(map_data) / 32'(TPR)) * 32'(TILE * ATLAS_W)
                       + 32'(ty1) * 32'(ATLAS_W) + 32'(tx1));
    spr_nxt = '0;
    for (int i = 0; i < NSPR; i++) begin
      if (hit1[i])
        spr_nxt[i*ATLAS_AW +: ATLAS_AW] =
          ATLAS_AW'(32'(base1[i]) + 32'(dy1[i]) * 32'(ATLAS_W) + 32'(dx1[i]));
    end
  end

  // Descending scan so the lowest-index opaque sprite wins.
  always_comb begin
    pix_c = tile_pix3;
    for (int i = NSPR - 1; i >= 0; i--) begin
      if (hit3[i] && (spr_pix3[i*16 +: 16] != KEY)) pix_c = spr_pix3[i*16 +: 16];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx1       <= '0;
      ty1       <= '0;
      draw1     <= 1'b0;
      hit1      <= '0;
      map_addr  <= '0;
      for (int i = 0; i < NSPR; i++) begin
        dx1[i]   <= '0;
        dy1[i]   <= '0;
        base1[i] <= '0;
      end
      draw2     <= 1'b0;
      hit2      <= '0;
      tile_addr <= '0;
      spr_addr  <= '0;
      draw3     <= 1'b0;
      hit3      <= '0;
      tile_pix3 <= '0;
      spr_pix3  <= '0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
    end else begin
      tx1      <= wx_c[TILE_LOG2-1:0];
      ty1      <= y_c[TILE_LOG2-1:0];
      draw1    <= draw_c;
      hit1     <= hit_c;
      map_addr <= MAP_AW'((32'(y_c) >> TILE_LOG2) * 32'(MAP_W) + (32'(wx_c) >> TILE_LOG2));
      for (int i = 0; i < NSPR; i++) begin
        dx1[i]   <= dx_c[i][TILE_LOG2-1:0];
        dy1[i]   <= dy_c[i][TILE_LOG2-1:0];
        base1[i] <= spr_base[i*ATLAS_AW +: ATLAS_AW];
      end
      draw2     <= draw1;
      hit2      <= hit1;
      tile_addr <= tile_nxt;
      spr_addr  <= spr_nxt;
      draw3     <= draw2;
      hit3      <= hit2;
      tile_pix3 <= tile_data;
      spr_pix3  <= spr_data;
      red       <= draw3 ? pix_c[15:12] : 4'd0;
      green     <= draw3 ? pix_c[10:7]  : 4'd0;
      blue      <= draw3 ? pix_c[4:1]   : 4'd0;
    end
  end

  // Sync delay line resets to the asserted (low) state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_d <= '0;
      vs_d <= '0;
      fs_d <= '0;
    end else begin
      hs_d <= {hs_d[2:0], hs_c};
      vs_d <= {vs_d[2:0], vs_c};
      fs_d <= {fs_d[2:0], fs_c};
    end
  end

  assign hs          = hs_d[3];
  assign vs          = vs_d[3];
  assign frame_start = fs_d[3];
endmodule
`default_nettype wire

// File: doc/vga_tile_renderer.md
# vga_tile_renderer

Parametrised pixel-pipeline successor to the current VGA output stage. It generates VGA sync timing from configurable parameters and fetches tile-map and tile-atlas pixels for a horizontally scrolled world. It overlays up to NSPR colour-keyed sprites with fixed priority and drives registered 4-bit RGB. It sits between the game logic (sprite positions, scroll requests) and the board VGA pins, and owns the read ports of the external map and atlas ROMs.

## Interface
Parameters:
- H_SYNC 112, H_BACK 248, H_ACTIVE 1280, H_FRONT 48: horizontal timing, in pixels.
- V_SYNC 3, V_BACK 38, V_ACTIVE 1024, V_FRONT 1: vertical timing, in lines.
- IMG_H 896: number of drawn lines; lines IMG_H..V_ACTIVE-1 are black.
- TILE_LOG2 6: tile and sprite edge is 2^TILE_LOG2 pixels.
- MAP_W 212: map width in tiles; the map is stored row-major.
- MAP_AW 12, ATLAS_AW 18: address widths.
- ATLAS_W 640: atlas row pitch in pixels.
- NSPR 2: number of sprite channels.
- KEY 16'd23743: transparent RGB565 value for sprites.
- SCROLL_MAX 12160: upper clamp for scroll, in pixels.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset; asynchronous, active-low.
- scroll_in  in  14  requested world-x offset of screen column 0.
- scroll_we  in  1  latches scroll_in as the pending scroll.
- spr_en  in  NSPR  sprite enables.
- spr_x  in  NSPR*11  sprite top-left x (screen); spr_y in NSPR*10 sprite top-left y.
- spr_base  in  NSPR*ATLAS_AW  atlas address of each sprite's top-left pixel.
- map_addr  out  MAP_AW  map ROM address; map_data in 6 tile id, valid 1 cycle after map_addr.
- tile_addr  out  ATLAS_AW  atlas port A; tile_data in 16, 1-cycle latency.
- spr_addr  out  NSPR*ATLAS_AW  atlas sprite ports; spr_data in NSPR*16, 1-cycle latency.
- red, green, blue  out  4 each  pixel colour.
- hs, vs  out  1  syncs, active-low.
- frame_start  out  1  one-cycle pulse.

## Operation
- Counters: h_cnt 0..COL-1 with COL = sum of H_*; v_cnt 0..ROW-1 with ROW = sum of V_*. v_cnt increments when h_cnt wraps. Both counters wrap together at (COL-1, ROW-1).
- Active region: h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE-1] and v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE-1], with exclusive upper bounds. Pixel coordinates are x = h_cnt - (H_SYNC+H_BACK) and y = v_cnt - (V_SYNC+V_BACK).
- Scroll:
  - scroll_we loads pending ← scroll_in; with repeated writes, the last one wins.
  - At h_cnt=0, v_cnt=0: scroll ← min(pending, SCROLL_MAX). The pending value is not cleared.
  - If scroll_we occurs in that same cycle, the new value becomes pending and applies next frame.
  - scroll never changes mid-frame.
- Tile fetch:
  - wx = x + scroll, using 15-bit arithmetic.
  - map_addr = (y>>TILE_LOG2)*MAP_W + (wx>>TILE_LOG2), truncated to MAP_AW.
  - The tile id returns from the map; base = (id % T)*2^TILE_LOG2 + (id / T)*2^TILE_LOG2*ATLAS_W, with T = ATLAS_W>>TILE_LOG2.
  - tile_addr = base + (y mod TILE)*ATLAS_W + (wx mod TILE).
- Sprites, per channel i:
  - hit_i = spr_en[i] && spr_x ≤ x < spr_x+2^TILE_LOG2 && spr_y ≤ y < spr_y+2^TILE_LOG2.
  - spr_addr_i = spr_base + (y-spr_y)*ATLAS_W + (x-spr_x).
  - When hit_i is 0, spr_addr_i is 0.
  - Sprite positions are sampled in the same stage as x and y.
- Compose:
  - Output the lowest-index channel with hit_i && spr_data_i ≠ KEY.
  - Otherwise output tile_data; tile pixels equal to KEY are drawn as-is.
  - RGB565 maps to red=[15:12], green=[10:7], blue=[4:1].
  - Black is forced outside the active region and for y ≥ IMG_H.

## Timing
- Pipeline, 4 cycles from counter to pins:
  - S1: register x, y, wx, map_addr.
  - S2: map_data returns; register tile_addr and spr_addr, delay the hit flags.
  - S3: tile_data and spr_data return.
  - S4: registered RGB.
- hs, vs, active and frame_start are delayed by 4 cycles so they align with RGB.
  - hs is low while the delayed h_cnt < H_SYNC.
  - vs is low while the delayed v_cnt < V_SYNC.
  - frame_start is high when the delayed counters are (0,0).
- Reset values: h_cnt, v_cnt, all pipeline registers, RGB, map_addr, tile_addr and spr_addr are 0. pending and scroll are 0. hs, vs and frame_start are 0 for 4 cycles after release, because the delay line resets to "sync" state.
- Reset asserted mid-line: all state clears immediately; after release, timing restarts from h_cnt=0, v_cnt=0.
- Sprite inputs may change at any cycle; a pixel uses the values sampled in its own S1.

## Test plan
- Reset release, then run 2 frames: the hs period is 1688 clocks, low for 112; the vs period is 1688*1066 clocks, low for 3 lines; frame_start pulses once per frame, 4 cycles after the counters hit (0,0).
- Scroll: scroll_we with 100 mid-frame → map_addr for x=0 is unchanged until the next frame, then equals 1 at y=0. Writing 20000 → scroll clamps to 12160.
- Map/atlas model with id=13 at map entry 0: pixel (5,3) → tile_addr = 3*64 + 1*64*640 + 3*640 + 5; RGB appears 4 cycles after S1.
- Two sprites overlapping at (100,100): when sprite 0's pixel is KEY, sprite 1's pixel is shown; when both are KEY, the tile pixel is shown. With spr_en=0, only tiles are shown.
- Boundaries: x=H_ACTIVE-1 is drawn, the next pixel is black; y=IMG_H-1 is drawn, y=IMG_H is black; a sprite at spr_x=1279 shows a 1-pixel column.
- Reset asserted mid-frame for 3 cycles → RGB=0 and counters=0; the following frame has exact timing.
